// File: rtl/tcp_to_bus.sv
`default_nettype none
// ============================================================================
// Module      : tcp_to_bus
// Description : SiTCP byte stream to bus-write bridge; parses LEN/ADDR frames
//               from a receive FIFO and issues one bus write per data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_to_bus #(
    parameter int DEPTH     = 16,
    parameter int ABUSWIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 TCP_RX_WR,
    input  logic [7:0]           TCP_RX_DATA,
    output logic [15:0]          TCP_RX_WC,
    input  logic                 RBCP_ACT,
    output logic                 BUS_WR,
    output logic [ABUSWIDTH-1:0] BUS_ADD,
    output logic [7:0]           BUS_DATA,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW
);

    localparam int c_PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_LEN_HI = 2'd0,
        ST_LEN_LO = 2'd1,
        ST_ADDR   = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    logic [7:0]           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_overflow;

    state_t               r_state;
    logic [7:0]           r_len_hi;
    logic [15:0]          r_remain;
    logic [1:0]           r_addr_cnt;
    logic [23:0]          r_addr_sh;
    logic [ABUSWIDTH-1:0] r_cur_addr;
    logic                 r_bus_wr;
    logic [ABUSWIDTH-1:0] r_bus_add;
    logic [7:0]           r_bus_data;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic [7:0]           w_rd_data;
    logic [31:0]          w_addr_full;

    assign w_full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop       = !w_empty && !RBCP_ACT;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
    assign w_push      = TCP_RX_WR && (!w_full || w_pop);
    assign w_rd_data   = r_mem[r_rd_ptr];
    assign w_addr_full = {r_addr_sh, w_rd_data};

    assign TCP_RX_WC  = {{(15-c_PTR_W){1'b1}}, r_count};
    assign BUS_WR     = r_bus_wr;
    assign BUS_ADD    = r_bus_add;
    assign BUS_DATA   = r_bus_data;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;
    assign OVERFLOW   = r_overflow;

    always_ff @(posedge BUS_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= TCP_RX_DATA;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_PTR_W+1)'(1);
            end
            if (TCP_RX_WR && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state      <= ST_LEN_HI;
            r_len_hi     <= '0;
            r_remain     <= '0;
            r_addr_cnt   <= '0;
            r_addr_sh    <= '0;
            r_cur_addr   <= '0;
            r_bus_wr     <= 1'b0;
            r_bus_add    <= '0;
            r_bus_data   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_bus_wr     <= 1'b0;
            r_bus_add    <= '0;
            r_bus_data   <= '0;
            r_frame_done <= 1'b0;
            // BUSY stays up through the FRAME_DONE cycle, unless a new frame starts
            if (r_frame_done) begin
                r_busy <= 1'b0;
            end
            if (w_pop) begin
                case (r_state)
                    ST_LEN_HI: begin
                        r_len_hi <= w_rd_data;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        r_remain   <= {r_len_hi, w_rd_data};
                        r_addr_cnt <= '0;
                        r_state    <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        r_addr_sh  <= {r_addr_sh[15:0], w_rd_data};
                        r_addr_cnt <= r_addr_cnt + 2'd1;
                        if (r_addr_cnt == 2'd3) begin
                            r_cur_addr <= ABUSWIDTH'(w_addr_full);
                            if (r_remain == 16'd0) begin
                                r_frame_done <= 1'b1;
                                r_state      <= ST_LEN_HI;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        r_bus_wr   <= 1'b1;
                        r_bus_add  <= r_cur_addr;
                        r_bus_data <= w_rd_data;
                        r_cur_addr <= r_cur_addr + ABUSWIDTH'(1);
                        r_remain   <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_LEN_HI;
                        end
                    end
                    default: r_state <= ST_LEN_HI;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
